// File: rtl/pipeline_sequencer.sv
// Pipeline valid/enable sequencer: per-stage valid bits with stall back-pressure and bubble
// collapse, front-end flush on correction, fetch handshake FSM with skid, timeout fault, retire count.
module pipeline_sequencer #(
    parameter int STAGES      = 5,
    parameter int FLUSH_DEPTH = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_WIDTH   = 32
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  correction_flag_in,
    input  logic [STAGES-1:0]     stall_req_in,
    output logic                  ins_mem_valid_out,
    input  logic                  ins_mem_ready_in,
    input  logic [DATA_WIDTH-1:0] ins_mem_data_in,
    output logic [DATA_WIDTH-1:0] fetch_data_out,
    output logic [STAGES-1:0]     stage_set_out,
    output logic [STAGES-1:0]     stage_clear_out,
    output logic [STAGES-1:0]     stage_valid_out,
    output logic                  fetch_fault_out,
    output logic [RET_WIDTH-1:0]  retire_count_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DISCARD = 2'd2,
        FAULT   = 2'd3
    } fetch_state_e;

    localparam logic [STAGES-1:0] KILL_MASK = STAGES'((32'd1 << FLUSH_DEPTH) - 32'd1);
    localparam logic [7:0]        TMO_LAST  = 8'(MEM_TIMEOUT - 1);

    fetch_state_e          state_q, state_d;
    logic [STAGES-1:0]     valid_q, valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  fault_q, fault_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [RET_WIDTH-1:0]  retire_q, retire_d;

    logic [STAGES-1:0]     hold_s;
    logic [STAGES-1:0]     in_s;
    logic [STAGES-1:0]     kill_s;
    logic                  fetch_done_s;
    logic                  retire_en_s;

    // Back-pressure ripples from the last stage forward; an empty stage breaks the chain
    always_comb begin
        logic carry;
        carry  = 1'b0;
        hold_s = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hold_s[i] = valid_q[i] & (stall_req_in[i] | carry);
            carry     = hold_s[i];
        end
    end

    // Stage arrivals, flush mask, register enables and next valid bits
    always_comb begin
        fetch_done_s = (state_q == REQUEST) & ins_mem_ready_in;
        in_s         = {valid_q[STAGES-2:0] & ~hold_s[STAGES-2:0], skid_valid_q | fetch_done_s};
        if (correction_flag_in) begin
            kill_s = KILL_MASK;
        end else begin
            kill_s = '0;
        end
        stage_set_out   = ~hold_s | kill_s;
        stage_clear_out = kill_s | (~hold_s & ~in_s);
        valid_d         = ~kill_s & ((hold_s & valid_q) | (~hold_s & in_s));
        retire_en_s     = valid_q[STAGES-1] & ~hold_s[STAGES-1];
        retire_d        = retire_q + {{(RET_WIDTH-1){1'b0}}, retire_en_s};
    end

    // Fetch handshake FSM, skid buffer and timeout counter
    always_comb begin
        state_d      = state_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        tmo_d        = 8'd0;
        fault_d      = fault_q;
        case (state_q)
            IDLE: begin
                if (skid_valid_q && !hold_s[0]) begin
                    skid_valid_d = 1'b0;
                end else begin
                    skid_valid_d = skid_valid_q;
                end
                if (!skid_valid_q && !hold_s[0] && !correction_flag_in && !fault_q) begin
                    state_d = REQUEST;
                end else begin
                    state_d = IDLE;
                end
            end
            REQUEST, DISCARD: begin
                if (ins_mem_ready_in) begin
                    if ((state_q == DISCARD) || correction_flag_in) begin
                        state_d = IDLE;
                    end else if (hold_s[0]) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = ins_mem_data_in;
                        state_d      = IDLE;
                    end else begin
                        state_d = REQUEST;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // The outstanding handshake is abandoned; the fault is sticky until reset
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (correction_flag_in) begin
                        state_d = DISCARD;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        skid_valid_d = skid_valid_d & ~correction_flag_in;
        mem_valid_d  = (state_d == REQUEST) || (state_d == DISCARD);
    end

    // State, handshake and counter registers
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            tmo_q        <= 8'd0;
            fault_q      <= 1'b0;
            mem_valid_q  <= 1'b0;
            retire_q     <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            tmo_q        <= tmo_d;
            fault_q      <= fault_d;
            mem_valid_q  <= mem_valid_d;
            retire_q     <= retire_d;
        end
    end

    assign ins_mem_valid_out = mem_valid_q;
    assign fetch_data_out    = skid_valid_q ? skid_data_q : ins_mem_data_in;
    assign stage_valid_out   = valid_q;
    assign fetch_fault_out   = fault_q;
    assign retire_count_out  = retire_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of pipeline occupancy and fetch handshake.
module tb_pipeline_sequencer;

    localparam int S   = 5;
    localparam int FD  = 3;
    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          corr  = 1'b0;
    logic          ready = 1'b0;
    logic [S-1:0]  stall = '0;
    logic [DW-1:0] mdata = '0;

    logic          ins_valid, fault, ins_valid4, fault4;
    logic [DW-1:0] fdata, fdata4;
    logic [S-1:0]  sset, sclr, sval, sset4, sclr4, sval4;
    logic [31:0]   ret;
    logic [3:0]    ret4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_sequencer dut (
        .clock_in(clk), .reset_in(rst), .correction_flag_in(corr), .stall_req_in(stall),
        .ins_mem_valid_out(ins_valid), .ins_mem_ready_in(ready), .ins_mem_data_in(mdata),
        .fetch_data_out(fdata), .stage_set_out(sset), .stage_clear_out(sclr),
        .stage_valid_out(sval), .fetch_fault_out(fault), .retire_count_out(ret)
    );

    pipeline_sequencer #(.RET_WIDTH(4)) dut4 (
        .clock_in(clk), .reset_in(rst), .correction_flag_in(corr), .stall_req_in(stall),
        .ins_mem_valid_out(ins_valid4), .ins_mem_ready_in(ready), .ins_mem_data_in(mdata),
        .fetch_data_out(fdata4), .stage_set_out(sset4), .stage_clear_out(sclr4),
        .stage_valid_out(sval4), .fetch_fault_out(fault4), .retire_count_out(ret4)
    );

    // Behavioural model: occupancy per stage, fetch mode 0=idle 1=request 2=discard 3=fault
    logic [S-1:0]  m_occ       = '0;
    int            m_mode      = 0;
    bit            m_skid      = 1'b0;
    logic [DW-1:0] m_skid_data = '0;
    int            m_wait      = 0;
    bit            m_fault     = 1'b0;
    logic [31:0]   m_ret       = '0;

    logic [S-1:0]  e_frozen, e_arrive, e_kill, e_set, e_clr;
    bit            e_valid;
    logic [DW-1:0] e_fdata;

    always_comb begin
        bit blocked_below;
        blocked_below = 1'b0;
        e_frozen = '0; e_arrive = '0; e_kill = '0; e_set = '0; e_clr = '0;
        for (int i = S - 1; i >= 0; i--) begin
            e_frozen[i]   = m_occ[i] && (stall[i] || blocked_below);
            blocked_below = e_frozen[i];
        end
        e_arrive[0] = m_skid || ((m_mode == 1) && ready);
        for (int i = 1; i < S; i++) e_arrive[i] = m_occ[i-1] && !e_frozen[i-1];
        for (int i = 0; i < S; i++) begin
            e_kill[i] = corr && (i < FD);
            e_set[i]  = !e_frozen[i] || e_kill[i];
            e_clr[i]  = e_kill[i] || (!e_frozen[i] && !e_arrive[i]);
        end
        e_valid = (m_mode == 1) || (m_mode == 2);
        e_fdata = m_skid ? m_skid_data : mdata;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_occ <= '0; m_mode <= 0; m_skid <= 1'b0; m_skid_data <= '0;
            m_wait <= 0; m_fault <= 1'b0; m_ret <= '0;
        end else begin
            for (int i = 0; i < S; i++)
                m_occ[i] <= e_kill[i] ? 1'b0 : (e_frozen[i] ? m_occ[i] : e_arrive[i]);
            if (m_occ[S-1] && !e_frozen[S-1]) m_ret <= m_ret + 32'd1;
            if (m_mode == 0) begin
                if (m_skid && !e_frozen[0]) m_skid <= 1'b0;
                if (!m_skid && !e_frozen[0] && !corr && !m_fault) m_mode <= 1;
            end else if (m_mode == 1 || m_mode == 2) begin
                if (ready) begin
                    m_wait <= 0;
                    if (m_mode == 2 || corr) m_mode <= 0;
                    else if (e_frozen[0]) begin
                        m_skid <= 1'b1; m_skid_data <= mdata; m_mode <= 0;
                    end
                end else if (m_wait + 1 >= TMO) begin
                    m_mode <= 3; m_fault <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                    if (corr) m_mode <= 2;
                end
            end
            if (corr) m_skid <= 1'b0;
        end
    end

    task automatic test_reset();
        rst = 1'b1; corr = 1'b0; stall = '0; ready = 1'b1; mdata = $urandom;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ins_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        checks++; if (ret !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d exp 0", ret); end
        checks++; if (sval !== 5'b00000) begin errors++; $display("FAIL reset_stage_valid got %b exp 00000", sval); end
        checks++; if (sset !== 5'b11111) begin errors++; $display("FAIL reset_set got %b exp 11111", sset); end
        checks++; if (sclr !== 5'b11111) begin errors++; $display("FAIL reset_clear got %b exp 11111", sclr); end
        checks++; if (ret4 !== 4'd0) begin errors++; $display("FAIL reset_retire4 got %0d exp 0", ret4); end
    endtask

    task automatic test_fill();
        logic [S-1:0] ev;
        int er;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            mdata = $urandom;
            #1;
            for (int i = 0; i < S; i++) ev[i] = (k >= 2 + i);
            er = (k >= 7) ? k - 6 : 0;
            checks++; if (ins_valid !== (k >= 1)) begin errors++; $display("FAIL fill_valid cyc %0d got %b", k, ins_valid); end
            checks++; if (sval !== ev) begin errors++; $display("FAIL fill_stage_valid cyc %0d got %b exp %b", k, sval, ev); end
            checks++; if (ret !== 32'(er)) begin errors++; $display("FAIL fill_retire cyc %0d got %0d exp %0d", k, ret, er); end
            checks++; if (ret4 !== 4'(er % 16)) begin errors++; $display("FAIL fill_retire_wrap cyc %0d got %0d exp %0d", k, ret4, er % 16); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_bubble();
        logic [31:0] r0, m0, delta;
        r0 = ret; m0 = m_ret;
        for (int k = 0; k < 20; k++) begin
            stall = (k < 3) ? 5'b00100 : 5'b00000;
            mdata = $urandom;
            #1;
            if (k < 3) begin
                checks++; if (sset[2:0] !== 3'b000) begin errors++; $display("FAIL stall_set cyc %0d got %b exp 000", k, sset[2:0]); end
                checks++; if (sclr[3] !== 1'b1) begin errors++; $display("FAIL stall_bubble_clear cyc %0d got %b exp 1", k, sclr[3]); end
            end
            if (k >= 1 && k <= 3) begin
                checks++; if (sval[3] !== 1'b0) begin errors++; $display("FAIL stall_bubble_v3 cyc %0d got %b exp 0", k, sval[3]); end
            end
            @(negedge clk);
        end
        delta = ret - r0;
        checks++; if (delta !== m_ret - m0) begin errors++; $display("FAIL stall_retire_count got %0d exp %0d", delta, m_ret - m0); end
        checks++; if (delta > 32'd17) begin errors++; $display("FAIL stall_retire_deficit got %0d exp at most 17", delta); end
    endtask

    task automatic test_skid();
        stall = 5'b00001; ready = 1'b0; mdata = $urandom;
        #1;
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL skid_pre_valid got %b exp 1", ins_valid); end
        @(negedge clk);
        ready = 1'b1; mdata = 32'hDEADBEEF;
        @(negedge clk);
        ready = 1'b0; mdata = 32'h0BADF00D;
        #1;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL skid_valid_drop got %b exp 0", ins_valid); end
        checks++; if (fdata !== 32'hDEADBEEF) begin errors++; $display("FAIL skid_data_held got %h exp deadbeef", fdata); end
        checks++; if (sset[0] !== 1'b0) begin errors++; $display("FAIL skid_set0_held got %b exp 0", sset[0]); end
        @(negedge clk);
        stall = 5'b00000; ready = 1'b1;
        #1;
        checks++; if (fdata !== 32'hDEADBEEF) begin errors++; $display("FAIL skid_drain_data got %h exp deadbeef", fdata); end
        checks++; if ({sset[0], sclr[0]} !== 2'b10) begin errors++; $display("FAIL skid_drain_set_clr got %b exp 10", {sset[0], sclr[0]}); end
        @(negedge clk);
        #1;
        checks++; if (sval[0] !== 1'b1) begin errors++; $display("FAIL skid_v0 got %b exp 1", sval[0]); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL skid_valid_gap got %b exp 0", ins_valid); end
        checks++; if (fdata !== mdata) begin errors++; $display("FAIL skid_passthru got %h exp %h", fdata, mdata); end
        @(negedge clk);
        #1;
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL skid_valid_back got %b exp 1", ins_valid); end
        @(negedge clk);
    endtask

    task automatic test_correction();
        ready = 1'b0; corr = 1'b1;
        #1;
        checks++; if (sclr[2:0] !== 3'b111) begin errors++; $display("FAIL corr_clear got %b exp 111", sclr[2:0]); end
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL corr_valid got %b exp 1", ins_valid); end
        @(negedge clk);
        corr = 1'b0;
        #1;
        checks++; if (sval[2:0] !== 3'b000) begin errors++; $display("FAIL corr_killed got %b exp 000", sval[2:0]); end
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL corr_valid_held got %b exp 1", ins_valid); end
        @(negedge clk);
        @(negedge clk);
        ready = 1'b1; mdata = $urandom;
        @(negedge clk);
        #1;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL discard_idle got %b exp 0", ins_valid); end
        checks++; if (sval[0] !== 1'b0) begin errors++; $display("FAIL discard_dropped got %b exp 0", sval[0]); end
        @(negedge clk);
        #1;
        checks++; if ({ins_valid, sval[0]} !== 2'b10) begin errors++; $display("FAIL discard_rerequest got %b exp 10", {ins_valid, sval[0]}); end
        @(negedge clk);
        #1;
        checks++; if (sval[0] !== 1'b1) begin errors++; $display("FAIL discard_refetch got %b exp 1", sval[0]); end
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] frozen;
        n = 0;
        ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            mdata = $urandom;
            @(negedge clk);
            #1;
            if (fault === 1'b1) begin
                n = k;
                break;
            end
        end
        checks++; if (n !== TMO) begin errors++; $display("FAIL timeout_cycles got %0d exp %0d", n, TMO); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid got %b exp 0", ins_valid); end
        repeat (8) begin
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        #1;
        checks++; if (sval !== 5'b00000) begin errors++; $display("FAIL fault_drained got %b exp 00000", sval); end
        checks++; if (ret !== m_ret) begin errors++; $display("FAIL fault_retire got %0d exp %0d", ret, m_ret); end
        frozen = m_ret;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (ret !== frozen) begin errors++; $display("FAIL fault_frozen got %0d exp %0d", ret, frozen); end
        checks++; if ({fault, ins_valid} !== 2'b10) begin errors++; $display("FAIL fault_sticky got %b exp 10", {fault, ins_valid}); end
        rst = 1'b1;
        #1;
        checks++; if ({fault, ins_valid} !== 2'b00) begin errors++; $display("FAIL fault_reset_flags got %b exp 00", {fault, ins_valid}); end
        checks++; if (ret !== 32'd0) begin errors++; $display("FAIL fault_reset_retire got %0d exp 0", ret); end
        checks++; if ({sset, sclr, sval} !== 15'b11111_11111_00000) begin errors++; $display("FAIL fault_reset_stage got %b", {sset, sclr, sval}); end
    endtask

    task automatic test_random();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < S; i++) stall[i] = ($urandom_range(0, 5) == 0);
            ready = ($urandom_range(0, 4) != 0);
            corr  = ($urandom_range(0, 11) == 0);
            mdata = $urandom;
            #1;
            checks++; if (ins_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, ins_valid, e_valid); end
            checks++; if (fault !== m_fault) begin errors++; $display("FAIL rnd_fault cyc %0d got %b exp %b", c, fault, m_fault); end
            checks++; if (sval !== m_occ) begin errors++; $display("FAIL rnd_stage_valid cyc %0d got %b exp %b", c, sval, m_occ); end
            checks++; if (sset !== e_set) begin errors++; $display("FAIL rnd_set cyc %0d got %b exp %b", c, sset, e_set); end
            checks++; if (sclr !== e_clr) begin errors++; $display("FAIL rnd_clear cyc %0d got %b exp %b", c, sclr, e_clr); end
            checks++; if (fdata !== e_fdata) begin errors++; $display("FAIL rnd_fetch_data cyc %0d got %h exp %h", c, fdata, e_fdata); end
            checks++; if (ret !== m_ret) begin errors++; $display("FAIL rnd_retire cyc %0d got %0d exp %0d", c, ret, m_ret); end
            checks++; if (ret4 !== m_ret[3:0]) begin errors++; $display("FAIL rnd_retire4 cyc %0d got %0d exp %0d", c, ret4, m_ret[3:0]); end
            checks++;
            if ({ins_valid4, fault4, sval4, sset4, sclr4, fdata4} !== {e_valid, m_fault, m_occ, e_set, e_clr, e_fdata}) begin
                errors++;
                $display("FAIL rnd_narrow_inst cyc %0d got %h exp %h", c, {ins_valid4, fault4, sval4, sset4, sclr4, fdata4},
                         {e_valid, m_fault, m_occ, e_set, e_clr, e_fdata});
            end
            @(negedge clk);
        end
        corr = 1'b0; stall = '0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall_bubble();
        test_skid();
        test_correction();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Parametrised successor to the core's fixed five-register pipeline control. Per stage it owns the valid bit and generates set and clear enables for STAGES pipeline registers. It also provides:
- per-stage stall back-pressure with bubble collapse
- branch-correction flush of the front stages
- an instruction-memory valid/ready fetch FSM with a one-entry skid buffer
- a fetch-timeout fault
- a retired-instruction counter

Parameters:
STAGES, 5, number of pipeline registers (stage 0 = PC/IF, STAGES-1 = EX/WB); legal range 2..16
FLUSH_DEPTH, 3, stages 0..FLUSH_DEPTH-1 killed on correction; 1 <= FLUSH_DEPTH < STAGES
DATA_WIDTH, 32, instruction word width
MEM_TIMEOUT, 15, cycles of valid without ready before fault; 1..255
RET_WIDTH, 32, retire counter width

Ports:
clock_in  in  1  core clock
reset_in  in  1  asynchronous, active-high reset
correction_flag_in  in  1  BRU misprediction correction, single-cycle
stall_req_in  in  STAGES  bit i: stage i cannot advance this cycle
ins_mem_valid_out  out  1  fetch request valid
ins_mem_ready_in  in  1  fetch response ready (data valid this cycle)
ins_mem_data_in  in  DATA_WIDTH  fetched instruction
fetch_data_out  out  DATA_WIDTH  instruction presented to stage 0
stage_set_out  out  STAGES  pipeline register write enables
stage_clear_out  out  STAGES  pipeline register clears (priority over set)
stage_valid_out  out  STAGES  per-stage valid bits
fetch_fault_out  out  1  sticky fetch-timeout fault
retire_count_out  out  RET_WIDTH  retired-instruction count

Behaviour:
- Reset (async, any cycle, including mid-handshake):
  - v = 0, skid_valid = 0, FSM = IDLE, timeout count = 0.
  - fault = 0, retire count = 0, ins_mem_valid_out = 0.
  - Resulting combinational outputs during reset: stage_set_out all 1, stage_clear_out all 1.
- Hold chain (combinational):
  - hold[S-1] = v[S-1] & stall_req_in[S-1].
  - hold[i] = v[i] & (stall_req_in[i] | hold[i+1]).
  - An empty stage never holds; a bubble is absorbed.
- Incoming valid:
  - in[0] = skid_valid | fetch_done, where fetch_done = (FSM==REQUEST) & ready.
  - in[i] = v[i-1] & !hold[i-1] for i > 0.
- Stage update:
  - kill[i] = correction_flag_in & (i < FLUSH_DEPTH).
  - stage_set_out[i] = !hold[i] | kill[i].
  - stage_clear_out[i] = kill[i] | (!hold[i] & !in[i]).
  - Next v[i] = kill ? 0 : hold ? v[i] : in[i].
- fetch_data_out = skid_valid ? skid_data : ins_mem_data_in.
- Fetch FSM states: IDLE, REQUEST, DISCARD, FAULT.
  - IDLE:
    - valid = 0.
    - -> REQUEST when !skid_valid & !hold[0] & !correction & !fault.
    - If skid_valid & !hold[0], the skid drains to stage 0 (skid_valid <= 0); the request is raised next cycle.
  - REQUEST:
    - valid = 1; valid never drops until ready.
    - ready & correction: data dropped -> IDLE.
    - ready & hold[0]: skid_valid <= 1, skid_data <= ins_mem_data_in -> IDLE.
    - ready otherwise: stage 0 captures; stay REQUEST. This gives one fetch per cycle with ready tied high.
    - !ready & correction -> DISCARD.
  - DISCARD:
    - valid = 1; on ready, data dropped, in[0] forced 0 -> IDLE.
    - A further correction keeps DISCARD.
  - FAULT:
    - valid = 0; fetch_fault_out = 1 until reset.
    - Later stages keep draining.
- Timeout:
  - Counter increments each REQUEST/DISCARD cycle with !ready; clears on ready.
  - Reaching MEM_TIMEOUT -> FAULT at the next edge; the outstanding handshake is abandoned.
- Skid:
  - Correction clears skid_valid (kill takes precedence over drain).
- Retire:
  - Increments when v[S-1] & !hold[S-1]; FLUSH_DEPTH < STAGES, so the last stage is never killed.
  - Wraps modulo 2^RET_WIDTH.
- Simultaneous stall and correction on a killed stage: the kill wins.

Test Plan:
1. Defaults, ready tied 1, no stalls; reset released at cycle 0 -> valid_out=1 at cycle 1, v[0]=1 at cycle 2, v[4]=1 at cycle 6, retire_count_out=1 at cycle 7, then +1 per cycle.
2. Steady flow, stall_req_in[2]=1 for cycles 10-12 -> stages 0-2 set_out=0 for those cycles; stage 3 clear_out=1 with v[3]=0 (bubble); exactly 3 fewer retires over 20 cycles.
3. Stage 0 stalled, ready pulse with data 0xDEADBEEF -> skid captures it; valid_out=0 next cycle. Release the stall -> fetch_data_out=0xDEADBEEF, v[0]=1, valid_out reasserts one cycle later.
4. REQUEST with ready=0, correction pulse -> v[0..2]=0 and clear_out[0..2]=1 next edge; valid_out stays 1. Ready after 3 cycles -> data dropped, v[0] stays 0, FSM IDLE then REQUEST.
5. Ready held 0 -> fetch_fault_out=1 after 15 wait cycles, valid_out=0; valid stages drain and retire, then counter frozen. Reset mid-fault -> all outputs return to reset values.
6. RET_WIDTH=4, 17 retires -> retire_count_out=1 (wrap).
